pb_pulse_array: RTL and testbench

Parametrised multi-channel pushbutton front end for the board's button inputs. Each channel synchronises a raw button, debounces it, and emits a one-cycle pulse on the selected edge(s). Each channel also flags a long press and optionally auto-repeats while the button is held. It sits between the raw board pins and every control FSM that consumes single-cycle button events.

---
 rtl/pb_pulse_pkg.sv | 19 +
 rtl/pb_pulse_array_if.sv | 14 +
 rtl/pb_pulse_array_channel.sv | 134 +++++++++++++
 rtl/pb_pulse_array.sv | 37 +++
 tb/tb_pb_pulse_array.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pb_pulse_pkg.sv
// Shared definitions for the pushbutton pulse array: edge-select mode
// encodings and the counter-width helper used to size per-channel counters.
package pb_pulse_pkg;

    // Edge select applied to every channel.
    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } pb_mode_e;

    // Width of a counter holding values 0..n-1. Never narrower than one bit,
    // so a count limit of 1 still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_pulse_array_if.sv
// Button bus between the board pins / consumers and pb_pulse_array.
// master drives raw buttons and mode; slave (the array) returns events.
interface pb_pulse_array_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] pb_in;
    logic [1:0]      mode;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] held;

    modport master (output pb_in, mode, input pulse, level, held);
    modport slave  (input pb_in, mode, output pulse, level, held);
endinterface

// File: rtl/pb_pulse_array_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce, edge pulse,
// long-press detect. Auto-repeat while held is built only when
// PB_AUTO_REPEAT_EN is defined.
module pb_channel
    import pb_pulse_pkg::*;
#(
    parameter int DB_CYCLES     = 20,
    parameter int HOLD_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pb_in,
    input  logic [1:0] mode,
    output logic       pulse,
    output logic       level,
    output logic       held
);
    localparam int DB_W   = cnt_w(DB_CYCLES);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic              s0, s1;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              level_nxt, lvl_flip, held_nxt;
    logic              edge_pulse, rep_fire;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= pb_in;
            s1 <= s0;
        end
    end

    // Debounce: accept s1 once it has disagreed with level for DB_CYCLES samples.
    always_comb begin
        db_cnt_nxt = db_cnt;
        level_nxt  = level;
        lvl_flip   = 1'b0;
        if (s1 == level) begin
            db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
            level_nxt  = s1;
            db_cnt_nxt = '0;
            lvl_flip   = 1'b1;
        end else begin
            db_cnt_nxt = db_cnt + 1'b1;
        end
    end

    // Hold counter: restarts on every flip and while released, saturates at the limit.
    // held uses the next count so it rises/falls on the same edge as the count.
    always_comb begin
        hold_nxt = hold_cnt;
        if (!level || lvl_flip)
            hold_nxt = '0;
        else if (hold_cnt != HOLD_MAX)
            hold_nxt = hold_cnt + 1'b1;
        held_nxt = (hold_nxt == HOLD_MAX);
    end

    // Edge event for the accepted flip, filtered by the edge-select mode.
    always_comb begin
        edge_pulse = 1'b0;
        if (lvl_flip) begin
            if (s1)
                edge_pulse = (mode == MODE_RISE) || (mode == MODE_BOTH);
            else
                edge_pulse = (mode == MODE_FALL) || (mode == MODE_BOTH);
        end
    end

`ifdef PB_AUTO_REPEAT_EN
    localparam int REP_W = cnt_w(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             rep_en;

    assign rep_en = (mode == MODE_RISE) || (mode == MODE_BOTH);

    // Repeat timer: fire as held rises, then every REPEAT_CYCLES edges.
    // Nothing fires on the release edge since held_nxt is already low there.
    always_comb begin
        rep_fire    = 1'b0;
        rep_cnt_nxt = rep_cnt;
        if (!held_nxt) begin
            rep_cnt_nxt = '0;
        end else if (!held) begin
            rep_cnt_nxt = '0;
            rep_fire    = rep_en;
        end else if (rep_en) begin
            if (rep_cnt == REP_LAST) begin
                rep_cnt_nxt = '0;
                rep_fire    = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rep_cnt <= '0;
        else       rep_cnt <= rep_cnt_nxt;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Channel state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level    <= 1'b0;
            db_cnt   <= '0;
            hold_cnt <= '0;
            held     <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            level    <= level_nxt;
            db_cnt   <= db_cnt_nxt;
            hold_cnt <= hold_nxt;
            held     <= held_nxt;
            pulse    <= edge_pulse | rep_fire;
        end
    end

endmodule

// File: rtl/pb_pulse_array.sv
// N_CH independent pushbutton channels sharing one edge-select mode.
// Optional auto-repeat is enabled with the PB_AUTO_REPEAT_EN macro.
module pb_pulse_array
    import pb_pulse_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int DB_CYCLES     = 20,
    parameter int HOLD_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 25
) (
    input logic              clock,
    input logic              reset,
    pb_pulse_array_if.slave  bus
);
    logic [N_CH-1:0] pulse_w, level_w, held_w;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pb_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .pb_in (bus.pb_in[g]),
            .mode  (bus.mode),
            .pulse (pulse_w[g]),
            .level (level_w[g]),
            .held  (held_w[g])
        );
    end

    assign bus.pulse = pulse_w;
    assign bus.level = level_w;
    assign bus.held  = held_w;

endmodule

// File: tb/tb_pb_pulse_array.sv
// Scoreboard bench for pb_pulse_array: each scenario builds per-cycle button
// waveforms, an event-level model derives expected pulse/level/held per edge,
// and a negedge monitor pops and compares them.
module tb_pb_pulse_array;
    import pb_pulse_pkg::*;

    localparam int N_CH = 2, DB = 4, HOLD = 16, REP = 5, MAXT = 400;

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] pulse;
        logic [N_CH-1:0] level;
        logic [N_CH-1:0] held;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic v [N_CH][MAXT];

    pb_pulse_array_if #(.N_CH(N_CH)) bus ();

    pb_pulse_array #(
        .N_CH(N_CH), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare the entry scheduled for the edge just taken.
    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.cyc == cyc && bus.pulse === mon_e.pulse &&
                bus.level === mon_e.level && bus.held === mon_e.held)
                n_pass++;
            else
                $display("FAIL sb edge %0d (sched %0d): pulse/level/held got %b/%b/%b want %b/%b/%b",
                         cyc, mon_e.cyc, bus.pulse, bus.level, bus.held,
                         mon_e.pulse, mon_e.level, mon_e.held);
        end
    end

    task automatic check_vec(input string name, input logic [3*N_CH-1:0] got,
                             input logic [3*N_CH-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b want %b", name, got, want);
    endtask

    task automatic clear_v();
        for (int ch = 0; ch < N_CH; ch++)
            for (int i = 0; i < MAXT; i++) v[ch][i] = 1'b0;
    endtask

    task automatic set_run(input int ch, input int start, input int len, input logic val);
        for (int i = start; i < start + len; i++) v[ch][i] = val;
    endtask

    // Model from the rules: a run of a new value lasting >= DB samples starting at
    // sample i flips level at edge i+1+DB; held covers [rise+HOLD, fall); repeats
    // at rise+HOLD+k*REP strictly before the fall.
    // Must be called just after a posedge (#1); drives v for T edges.
    task automatic run_scn(input logic [1:0] m, input int T);
        logic [N_CH-1:0] ep [MAXT];
        logic [N_CH-1:0] el [MAXT];
        logic [N_CH-1:0] eh [MAXT];
        int   fl_e[$];
        logic fl_v[$];
        int   base;
        exp_t e_item;
        for (int e = 0; e < T; e++) begin
            ep[e] = '0; el[e] = '0; eh[e] = '0;
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            logic lvl;
            int i, j, f;
            fl_e.delete(); fl_v.delete();
            lvl = 1'b0; i = 0;
            while (i < T) begin
                j = i;
                while (j < T && v[ch][j] == v[ch][i]) j++;
                if (v[ch][i] != lvl && (j - i) >= DB) begin
                    fl_e.push_back(i + 1 + DB);
                    fl_v.push_back(v[ch][i]);
                    lvl = v[ch][i];
                end
                i = j;
            end
            for (int k = 0; k < fl_e.size(); k++) begin
                f = (k + 1 < fl_e.size()) ? fl_e[k+1] : T;
                for (int e = fl_e[k]; e < f && e < T; e++) el[e][ch] = fl_v[k];
                if (fl_e[k] < T && (fl_v[k] ? (m == MODE_RISE || m == MODE_BOTH)
                                            : (m == MODE_FALL || m == MODE_BOTH)))
                    ep[fl_e[k]][ch] = 1'b1;
                if (fl_v[k]) begin
                    for (int e = fl_e[k] + HOLD; e < f && e < T; e++) eh[e][ch] = 1'b1;
`ifdef PB_AUTO_REPEAT_EN
                    if (m == MODE_RISE || m == MODE_BOTH)
                        for (int e = fl_e[k] + HOLD; e < f && e < T; e += REP) ep[e][ch] = 1'b1;
`endif
                end
            end
        end
        base = cyc + 1;
        for (int e = 0; e < T; e++) begin
            e_item.cyc = base + e; e_item.pulse = ep[e];
            e_item.level = el[e]; e_item.held = eh[e];
            sb.push_back(e_item);
        end
        bus.mode = m;
        for (int i = 0; i < T; i++) begin
            for (int ch = 0; ch < N_CH; ch++) bus.pb_in[ch] = v[ch][i];
            @(posedge clock);
            #1;
        end
    endtask

    task automatic gen_random(output int T);
        int pos, len, r, nseg;
        logic val;
        clear_v();
        T = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            pos = 0; val = 1'b1;
            nseg = int'($urandom_range(2, 6));
            for (int s = 0; s < nseg; s++) begin
                r = int'($urandom_range(0, 2));
                case (r)
                    0:       len = int'($urandom_range(1, DB - 1));
                    1:       len = int'($urandom_range(DB, DB + 8));
                    default: len = int'($urandom_range(HOLD + 1, HOLD + 4 * REP + 4));
                endcase
                set_run(ch, pos, len, val);
                pos += len;
                val = ~val;
            end
            if (pos > T) T = pos;
        end
        T = T + DB + 6;
    endtask

    initial begin
        int T;
        bus.pb_in = '0;
        bus.mode  = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        check_vec("reset_state", {bus.pulse, bus.level, bus.held}, '0);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        // Glitch of 3 samples rejected, 4 samples accepted.
        clear_v(); set_run(0, 0, 3, 1'b1); set_run(0, 20, 4, 1'b1);
        run_scn(MODE_RISE, 40);

        // Press/release channel 1 under every mode.
        for (int m = 0; m < 4; m++) begin
            clear_v(); set_run(1, 0, 30, 1'b1);
            run_scn(2'(m), 50);
        end

        // Long press.
        clear_v(); set_run(0, 0, 40, 1'b1);
        run_scn(MODE_RISE, 60);

        // Independence: channel 1 pressed 2 cycles after channel 0.
        clear_v(); set_run(0, 0, 10, 1'b1); set_run(1, 2, 10, 1'b1);
        run_scn(MODE_BOTH, 40);

        // Random waveforms under random modes.
        repeat (12) begin
            gen_random(T);
            run_scn(2'($urandom_range(0, 3)), T);
        end

        // Mid-run asynchronous reset with both buttons held.
        bus.pb_in = '1;
        repeat (30) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_vec("async_reset", {bus.pulse, bus.level, bus.held}, '0);
        repeat (3) @(posedge clock);
        #1;
        check_vec("reset_held", {bus.pulse, bus.level, bus.held}, '0);
        reset = 1'b0;
        clear_v(); set_run(0, 0, 30, 1'b1); set_run(1, 0, 30, 1'b1);
        run_scn(MODE_RISE, 50);

        @(negedge clock);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d entries left want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
